// File: rtl/data_sram_responder.sv
// Word-organised SRAM responder for a cache memory port: one outstanding
// request, configurable accept delay and fixed completion latency.
module data_sram_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2,
  parameter int ADDR_DELAY = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_addr_ok,
  output logic        o_data_ok
);

  // Handshake: a request is accepted in the cycle o_addr_ok=1 (i_req high,
  // responder idle, accept delay expired); o_data_ok pulses exactly LATENCY
  // cycles later. Attributes are sampled only in the accept cycle.

  localparam int         DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAT_M1  = 4'(LATENCY - 1);
  localparam logic [3:0] DLY_CNT = 4'(ADDR_DELAY);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_dcnt;
  logic [3:0]              r_lcnt;
  logic                    r_wr;
  logic [1:0]              r_size;
  logic [1:0]              r_off;
  logic [ADDR_WIDTH-1:0]   r_idx;
  logic [31:0]             r_wdata;
  logic [31:0]             r_rdata;
  logic [31:0]             r_mem [DEPTH];
  logic                    w_accept;
  logic                    w_rd_resp;
  logic [3:0]              w_mask;
  logic                    w_unused_addr;

  assign w_unused_addr = ^i_addr[31:ADDR_WIDTH+2];

  // Gated by reset so the combinational accept drops the instant reset rises.
  assign w_accept  = i_req & ~i_rst & (r_state == ST_IDLE) & (r_dcnt == DLY_CNT);
  assign w_rd_resp = (r_state == ST_RESP) & ~r_wr;

  assign o_addr_ok = w_accept;
  assign o_data_ok = (r_state == ST_RESP);
  assign o_rdata   = w_rd_resp ? r_mem[r_idx] : r_rdata;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = (LATENCY == 1) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (r_lcnt == 4'd1) w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_mask = 4'b1111;
    case (r_size)
      2'b00:   w_mask = 4'b0001 << r_off;
      2'b01:   w_mask = r_off[1] ? 4'b1100 : 4'b0011;
      default: w_mask = 4'b1111;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_dcnt  <= 4'd0;
      r_lcnt  <= 4'd0;
      r_wr    <= 1'b0;
      r_size  <= 2'b00;
      r_off   <= 2'b00;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      // Delay counter only advances while a request waits in IDLE.
      if ((r_state == ST_IDLE) && i_req && !w_accept) r_dcnt <= r_dcnt + 4'd1;
      else                                            r_dcnt <= 4'd0;
      if (w_accept) begin
        r_lcnt  <= LAT_M1;
        r_wr    <= i_wr;
        r_size  <= i_size;
        r_off   <= i_addr[1:0];
        r_idx   <= i_addr[ADDR_WIDTH+1:2];
        r_wdata <= i_wdata;
      end else if (r_state == ST_WAIT) begin
        r_lcnt <= r_lcnt - 4'd1;
      end
      if (w_rd_resp) r_rdata <= r_mem[r_idx];
    end
  end

  // Array has no reset; a reset forces IDLE so an abandoned write never lands.
  always_ff @(posedge i_clk) begin
    if ((r_state == ST_RESP) && r_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_mask[b]) r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: three instances cover the default timing,
// a delayed-accept configuration and single-cycle latency.
module tb_data_sram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic        rst     [3];
  logic        req     [3];
  logic        wr      [3];
  logic [1:0]  size    [3];
  logic [31:0] addr    [3];
  logic [31:0] wdata   [3];
  logic [31:0] rdata   [3];
  logic        addr_ok [3];
  logic        data_ok [3];

  int lat_of [3] = '{2, 3, 1};
  int dly_of [3] = '{0, 3, 0};

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] mdl [3][8];

  data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(2), .ADDR_DELAY(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst[0]), .i_req(req[0]), .i_wr(wr[0]), .i_size(size[0]),
    .i_addr(addr[0]), .i_wdata(wdata[0]), .o_rdata(rdata[0]),
    .o_addr_ok(addr_ok[0]), .o_data_ok(data_ok[0]));

  data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(3), .ADDR_DELAY(3)) u_dut1 (
    .i_clk(clk), .i_rst(rst[1]), .i_req(req[1]), .i_wr(wr[1]), .i_size(size[1]),
    .i_addr(addr[1]), .i_wdata(wdata[1]), .o_rdata(rdata[1]),
    .o_addr_ok(addr_ok[1]), .o_data_ok(data_ok[1]));

  data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(1), .ADDR_DELAY(0)) u_dut2 (
    .i_clk(clk), .i_rst(rst[2]), .i_req(req[2]), .i_wr(wr[2]), .i_size(size[2]),
    .i_addr(addr[2]), .i_wdata(wdata[2]), .o_rdata(rdata[2]),
    .o_addr_ok(addr_ok[2]), .o_data_ok(data_ok[2]));

  // Reference write rule: selected byte lanes of new data replace the old word.
  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [1:0] sz, input logic [1:0] off);
    logic [3:0]  m;
    logic [31:0] r;
    r = old_w;
    case (sz)
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = off[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // One transaction: wt = cycles from req to addr_ok, lat = cycles from
  // addr_ok to data_ok (-1 when the bound expires), rd = rdata at data_ok.
  task automatic txn(input int d, input logic w, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output int lat, output int wt);
    int  t0, ta;
    bit  got;
    got = 0; lat = -1; wt = -1; rd = 'x; ta = 0;
    @(negedge clk);
    req[d] = 1'b1; wr[d] = w; size[d] = sz; addr[d] = a; wdata[d] = wd;
    t0 = cyc;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (addr_ok[d] === 1'b1) begin got = 1; ta = cyc; break; end
      @(negedge clk);
    end
    if (!got) begin req[d] = 1'b0; return; end
    wt = ta - t0;
    @(negedge clk);
    req[d] = 1'b0;
    for (int k = 0; k < 40; k++) begin
      wr[d] = 1'($urandom); size[d] = 2'($urandom); addr[d] = $urandom; wdata[d] = $urandom;
      #1;
      if (data_ok[d] === 1'b1) begin lat = cyc - ta; rd = rdata[d]; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      req[d] = 1'b1; wr[d] = 1'b0; size[d] = 2'b10; addr[d] = 32'h0; wdata[d] = 32'h0;
    end
    @(posedge clk); #2;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (addr_ok[d] !== 1'b0) begin n_fail++; $display("FAIL reset_addr_ok dut%0d: got %b want 0", d, addr_ok[d]); end
      n_cmp++;
      if (data_ok[d] !== 1'b0) begin n_fail++; $display("FAIL reset_data_ok dut%0d: got %b want 0", d, data_ok[d]); end
      n_cmp++;
      if (rdata[d] !== 32'h0) begin n_fail++; $display("FAIL reset_rdata dut%0d: got %h want 0", d, rdata[d]); end
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin rst[d] = 1'b0; req[d] = 1'b0; end
  endtask

  task automatic test_directed();
    logic [31:0] rd;
    int lat, wt;
    txn(0, 1'b1, 2'b10, 32'h40, 32'hDEADBEEF, rd, lat, wt);
    n_cmp++;
    if (wt !== 0) begin n_fail++; $display("FAIL first_accept_wait: got %0d want 0", wt); end
    n_cmp++;
    if (lat !== 2) begin n_fail++; $display("FAIL word_wr_latency: got %0d want 2", lat); end
    txn(0, 1'b0, 2'b10, 32'h40, $urandom, rd, lat, wt);
    n_cmp++;
    if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_rd: got %h want deadbeef", rd); end
    txn(0, 1'b1, 2'b00, 32'h41, 32'h0000AA00, rd, lat, wt);
    txn(0, 1'b0, 2'b10, 32'h40, $urandom, rd, lat, wt);
    n_cmp++;
    if (rd !== 32'hDEADAAEF) begin n_fail++; $display("FAIL byte_wr: got %h want deadaaef", rd); end
    txn(0, 1'b1, 2'b01, 32'h42, 32'h12340000, rd, lat, wt);
    txn(0, 1'b0, 2'b00, 32'h00001040, $urandom, rd, lat, wt);
    n_cmp++;
    if (rd !== 32'h1234AAEF) begin n_fail++; $display("FAIL half_wr_alias_rd: got %h want 1234aaef", rd); end
    @(negedge clk); #1;
    n_cmp++;
    if (rdata[0] !== 32'h1234AAEF) begin n_fail++; $display("FAIL rdata_hold_idle: got %h want 1234aaef", rdata[0]); end
    txn(0, 1'b1, 2'b10, 32'h44, 32'h55555555, rd, lat, wt);
    n_cmp++;
    if (rd !== 32'h1234AAEF) begin n_fail++; $display("FAIL rdata_hold_write: got %h want 1234aaef", rd); end
  endtask

  task automatic test_addr_delay();
    logic [31:0] rd;
    int lat, wt;
    txn(1, 1'b1, 2'b10, 32'h100, 32'hCAFE0001, rd, lat, wt);
    n_cmp++;
    if (wt !== 3) begin n_fail++; $display("FAIL delay_held_wait: got %0d want 3", wt); end
    n_cmp++;
    if (lat !== 3) begin n_fail++; $display("FAIL delay_latency: got %0d want 3", lat); end
    @(negedge clk);
    req[1] = 1'b1; wr[1] = 1'b0; size[1] = 2'b10; addr[1] = 32'h100;
    for (int k = 0; k < 2; k++) begin
      #1; n_cmp++;
      if (addr_ok[1] !== 1'b0) begin n_fail++; $display("FAIL delay_early k%0d: got %b want 0", k, addr_ok[1]); end
      @(negedge clk);
    end
    req[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1; n_cmp++;
      if (addr_ok[1] !== 1'b0) begin n_fail++; $display("FAIL delay_dropped k%0d: got %b want 0", k, addr_ok[1]); end
      @(negedge clk);
    end
    req[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1; n_cmp++;
      if (addr_ok[1] !== (k == 3)) begin n_fail++; $display("FAIL delay_restart k%0d: got %b want %b", k, addr_ok[1], k == 3); end
      @(negedge clk);
    end
    req[1] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1; n_cmp++;
      if (data_ok[1] !== (k == 3)) begin n_fail++; $display("FAIL delay_restart_data k%0d: got %b want %b", k, data_ok[1], k == 3); end
      @(negedge clk);
    end
    txn(1, 1'b0, 2'b10, 32'h100, 32'h0, rd, lat, wt);
    n_cmp++;
    if (rd !== 32'hCAFE0001) begin n_fail++; $display("FAIL delay_rd: got %h want cafe0001", rd); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req[2] = 1'b1; wr[2] = 1'b0; size[2] = 2'b10; addr[2] = $urandom;
    for (int k = 0; k < 10; k++) begin
      #1; n_cmp++;
      if (addr_ok[2] !== (k % 2 == 0)) begin n_fail++; $display("FAIL b2b_addr_ok k%0d: got %b want %b", k, addr_ok[2], k % 2 == 0); end
      n_cmp++;
      if (data_ok[2] !== (k % 2 == 1)) begin n_fail++; $display("FAIL b2b_data_ok k%0d: got %b want %b", k, data_ok[2], k % 2 == 1); end
      @(negedge clk);
      addr[2] = $urandom;
    end
    req[2] = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int lat, wt;
    txn(0, 1'b1, 2'b10, 32'h80, 32'h22222222, rd, lat, wt);
    @(negedge clk);
    req[0] = 1'b1; wr[0] = 1'b1; size[0] = 2'b10; addr[0] = 32'h80; wdata[0] = 32'h11111111;
    #1; n_cmp++;
    if (addr_ok[0] !== 1'b1) begin n_fail++; $display("FAIL rstmid_accept: got %b want 1", addr_ok[0]); end
    @(negedge clk);
    #1; rst[0] = 1'b1;
    #1; n_cmp++;
    if (data_ok[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_data_ok: got %b want 0", data_ok[0]); end
    n_cmp++;
    if (addr_ok[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_addr_ok: got %b want 0", addr_ok[0]); end
    @(posedge clk); #1; n_cmp++;
    if (data_ok[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_held: got %b want 0", data_ok[0]); end
    @(negedge clk);
    rst[0] = 1'b0; req[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1; n_cmp++;
      if (data_ok[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_after k%0d: got %b want 0", k, data_ok[0]); end
      @(negedge clk);
    end
    txn(0, 1'b0, 2'b10, 32'h80, 32'h0, rd, lat, wt);
    n_cmp++;
    if (rd !== 32'h22222222) begin n_fail++; $display("FAIL rstmid_rd: got %h want 22222222", rd); end
  endtask

  task automatic test_random(input int d);
    logic [31:0] rd, a, wd;
    logic [1:0]  sz, off;
    logic        w;
    int lat, wt, base, k;
    base = $urandom_range(64, 1000);
    for (int i = 0; i < 8; i++) begin
      wd = $urandom;
      mdl[d][i] = wd;
      txn(d, 1'b1, 2'b10, 32'((base + i) << 2), wd, rd, lat, wt);
    end
    for (int n = 0; n < 40; n++) begin
      k   = $urandom_range(0, 7);
      off = 2'($urandom);
      sz  = 2'($urandom);
      w   = 1'($urandom);
      wd  = $urandom;
      a   = (32'(base + k) << 2) | 32'(off) | ($urandom & 32'hFFFFF000);
      txn(d, w, sz, a, wd, rd, lat, wt);
      n_cmp++;
      if (wt !== dly_of[d]) begin n_fail++; $display("FAIL rand_wait dut%0d n%0d: got %0d want %0d", d, n, wt, dly_of[d]); end
      n_cmp++;
      if (lat !== lat_of[d]) begin n_fail++; $display("FAIL rand_latency dut%0d n%0d: got %0d want %0d", d, n, lat, lat_of[d]); end
      if (w) begin
        mdl[d][k] = merge(mdl[d][k], wd, sz, off);
      end else begin
        n_cmp++;
        if (rd !== mdl[d][k]) begin n_fail++; $display("FAIL rand_rd dut%0d n%0d: got %h want %h", d, n, rd, mdl[d][k]); end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; req[d] = 1'b0; wr[d] = 1'b0; size[d] = 2'b00;
      addr[d] = 32'h0; wdata[d] = 32'h0;
    end
    test_reset();
    test_directed();
    test_addr_delay();
    test_back_to_back();
    test_reset_mid();
    test_random(0);
    test_random(1);
    test_random(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
